mult_pipe_wrapper: RTL and testbench
====================================

Name: mult_pipe_wrapper

Overview:
- Parametrised, pipelined successor to the fixed 16-bit registered multiplier wrapper.
- Accepts one operand pair per cycle under a valid/ready handshake and supports per-transaction signed/unsigned mode.
- Retimes the product through a configurable number of output stages, with bubble-collapsing backpressure.
- Sits between a stimulus source and a result consumer in multiplier characterisation runs.

Parameters:
- WIDTH, 16, operand width in bits (>=2); product is 2*WIDTH bits.
- STAGES, 2, number of product register stages after the input register (>=1).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept the pair this cycle.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
- multiplicand  input  WIDTH  operand A.
- multiplier  input  WIDTH  operand B.
- out_valid  output  1  product present.
- out_ready  input  1  consumer accepts the product this cycle.
- product  output  2*WIDTH  result.
- out_signed  output  1  is_signed value that produced the current product.

Behaviour:
- Structure:
  - Input stage S0 holds A, B, is_signed and a valid bit.
  - The combinational multiply feeds stages S1..S_STAGES, each holding product, signed flag and a valid bit.
  - S_STAGES drives the outputs.
- Arithmetic:
  - Unsigned mode: full 2*WIDTH-bit zero-extended product.
  - Signed mode: both operands sign-extended to 2*WIDTH bits; result is the exact product, with no overflow and no truncation.
- Stage advance rule, stage k:
  - adv_k = !v_k | adv_{k+1}.
  - adv for the last stage = !v_last | out_ready.
  - When adv_k, stage k loads from stage k-1 (valid included). Otherwise it holds.
- in_ready = adv_0. It is combinational from out_ready and the valid bits; there is no combinational path from in_valid.
- Acceptance:
  - A transfer occurs when in_valid & in_ready.
  - S0 valid loads in_valid whenever adv_0 is high, so bubbles propagate.
- Latency: a pair accepted in cycle t appears with out_valid=1 in cycle t+STAGES+1 when out_ready is held high.
- Throughput: 1 per cycle.
- Backpressure:
  - When out_ready=0 with out_valid=1, product and out_signed stay stable until the handshake.
  - Upstream stages keep filling any empty slots.
  - in_ready drops only when all STAGES+1 slots are valid.
- Capacity: STAGES+1 transactions in flight. Order is strictly preserved.
- Simultaneous events: with a full pipe and out_ready=1, in_ready=1 in the same cycle, and a new pair is accepted while the oldest is consumed.
- Data registers are updated only on advance. Their contents are don't-care while the stage valid is 0.
- Reset:
  - All valid bits clear immediately (out_valid=0). product=0 and out_signed=0.
  - in_ready is 1 while reset is released, i.e. the pipe is empty.
  - Reset mid-operation discards all in-flight transactions. No partial results are emitted after release.
  - Data registers are reset to 0.
- X-safety: product is never driven from an invalid stage while out_valid=1.

Optional Feature:
- Macro: MULT_PIPE_STATS_EN.
- With the macro defined, two additional output ports are added:
  - txn_count: output, 32 bits. Increments on each out_valid & out_ready; saturates at 0xFFFFFFFF.
  - stall_count: output, 32 bits. Increments on each cycle with out_valid & !out_ready; saturates at 0xFFFFFFFF.
  - Both clear to 0 on rst.
- Without the macro, these ports and their counters are absent. All other behaviour is identical.

Test Plan:
- Unsigned basic, WIDTH=16, STAGES=2:
  - Stimulus: A=0xFFFF, B=0xFFFF, is_signed=0, accepted at cycle t, out_ready=1.
  - Required: product=0xFFFE0001, out_valid at t+3, out_signed=0.
- Signed mode:
  - A=0xFFFF (-1), B=0x0002, is_signed=1 -> product=0xFFFFFFFE.
  - A=0x8000, B=0x8000, is_signed=1 -> product=0x40000000.
- Back-to-back streaming:
  - Stimulus: 100 random pairs, mixed modes, in_valid and out_ready held at 1.
  - Required: one result per cycle, in order, each matching the reference model; in_ready stays 1.
- Backpressure fill:
  - Stimulus: out_ready=0, feed 4 pairs.
  - Required: 3 accepted, then in_ready=0; product stays stable.
  - Then raise out_ready: results drain in order, and the 4th pair is accepted in the same cycle the first result is consumed.
- Reset mid-stream:
  - Stimulus: assert rst asynchronously while 2 transactions are in flight.
  - Required: out_valid=0 and product=0 without waiting for a clock edge; after release, in_ready=1 and no stale result appears.
- MULT_PIPE_STATS_EN build:
  - Stimulus: 5 transfers and 7 stalled cycles.
  - Required: txn_count=5, stall_count=7; both read 0 after rst.

Source files
------------

// File: rtl/mult_pipe_wrapper.sv
// ---------------------------------------------------------------------------
// mult_pipe_wrapper
//
// Pipelined WIDTH x WIDTH multiplier with a valid/ready handshake on both
// sides and a per-transaction signed/unsigned mode. One input register (S0)
// holds the operands. The product is retimed through STAGES output registers
// (S1..S_STAGES). Backpressure collapses bubbles: a stage loads whenever it
// is empty or the stage after it is advancing.
//
// Parameters:
//   WIDTH   operand width (>=2); product is 2*WIDTH bits
//   STAGES  product register stages after the input register (>=1)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     operand pair present
//   in_ready     pair can be accepted this cycle (no path from in_valid)
//   is_signed    1 = two's-complement operands, sampled with the operands
//   multiplicand operand A
//   multiplier   operand B
//   out_valid    product present
//   out_ready    consumer accepts the product this cycle
//   product      2*WIDTH-bit result
//   out_signed   mode that produced the current product
//   txn_count    (MULT_PIPE_STATS_EN only) saturating count of output handshakes
//   stall_count  (MULT_PIPE_STATS_EN only) saturating count of stalled output cycles
//
// Optional feature macro: MULT_PIPE_STATS_EN
// ---------------------------------------------------------------------------
module mult_pipe_wrapper #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               out_signed
`ifdef MULT_PIPE_STATS_EN
  ,
  output logic [31:0]        txn_count,
  output logic [31:0]        stall_count
`endif
);

  localparam int PW = 2 * WIDTH;

  // Input stage S0
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_s0_signed;
  logic             r_s0_valid;

  // Product stages S1..S_STAGES
  logic [PW-1:0]    r_prod [1:STAGES];
  logic [STAGES:1]  r_sgn;
  logic [STAGES:1]  r_vld;

  logic [STAGES:1]  w_adv;
  logic             w_adv0;
  logic [PW-1:0]    w_ext_a;
  logic [PW-1:0]    w_ext_b;
  logic [PW-1:0]    w_mult;

  // Extending both operands to the full product width makes the low PW bits
  // of a plain multiply the exact result in either mode; a signed product of
  // two WIDTH-bit values always fits in PW bits.
  assign w_ext_a = r_s0_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_ext_b = r_s0_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_mult  = w_ext_a * w_ext_b;

  // Advance chain: stage k may load unless it and every later stage are full
  // while the consumer is stalling. This is the unrolled form of
  // adv_k = !v_k | adv_{k+1}, written with a running "all full" term so the
  // vector never feeds itself.
  always_comb begin : adv_chain
    logic v_full;
    // NOTE: every variable gets a default before any conditional logic, so
    // no path through this block leaves a value unassigned (no latch).
    v_full = 1'b1;
    w_adv  = '0;
    for (int k = STAGES; k >= 1; k--) begin
      v_full   = v_full & r_vld[k];
      w_adv[k] = out_ready | ~v_full;
    end
    w_adv0 = out_ready | ~(v_full & r_s0_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the product array is cleared explicitly in a loop so the output
      // reads 0 during and right after reset; it is small, so this is cheap.
      r_a         <= '0;
      r_b         <= '0;
      r_s0_signed <= 1'b0;
      r_s0_valid  <= 1'b0;
      r_sgn       <= '0;
      r_vld       <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        r_prod[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's pre-edge value, which is what makes this a shift pipeline.
      if (w_adv0) begin
        r_s0_valid  <= in_valid;  // loads bubbles too
        r_a         <= multiplicand;
        r_b         <= multiplier;
        r_s0_signed <= is_signed;
      end
      if (w_adv[1]) begin
        r_vld[1]  <= r_s0_valid;
        r_sgn[1]  <= r_s0_signed;
        r_prod[1] <= w_mult;
      end
      for (int k = 2; k <= STAGES; k++) begin
        if (w_adv[k]) begin
          r_vld[k]  <= r_vld[k-1];
          r_sgn[k]  <= r_sgn[k-1];
          r_prod[k] <= r_prod[k-1];
        end
      end
    end
  end

  assign in_ready   = w_adv0;
  assign out_valid  = r_vld[STAGES];
  assign product    = r_prod[STAGES];
  assign out_signed = r_sgn[STAGES];

`ifdef MULT_PIPE_STATS_EN
  logic [31:0] r_txn_count;
  logic [31:0] r_stall_count;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txn_count   <= '0;
      r_stall_count <= '0;
    end else begin
      if (out_valid && out_ready && (r_txn_count != 32'hFFFF_FFFF)) begin
        r_txn_count <= r_txn_count + 32'd1;
      end
      if (out_valid && !out_ready && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign txn_count   = r_txn_count;
  assign stall_count = r_stall_count;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mult_pipe_wrapper.sv
// ---------------------------------------------------------------------------
// Testbench for mult_pipe_wrapper (WIDTH=16, STAGES=2).
// Reference model: a queue of expected results computed with plain integer
// arithmetic when a pair is accepted, compared in order when a result is
// consumed. Statistics ports are exercised when MULT_PIPE_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_mult_pipe_wrapper;

  localparam int W  = 16;
  localparam int ST = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          is_signed;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] product;
  logic          out_signed;
`ifdef MULT_PIPE_STATS_EN
  logic [31:0]   txn_count;
  logic [31:0]   stall_count;
`endif

  mult_pipe_wrapper #(.WIDTH(W), .STAGES(ST)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .out_signed   (out_signed)
`ifdef MULT_PIPE_STATS_EN
    ,
    .txn_count    (txn_count),
    .stall_count  (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prod;
    logic        sgn;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_out    = 0;
  int last_lat = 0;
  logic [31:0] last_prod;
  logic        last_acc;
  logic        last_cons;
  logic        chk_lat   = 1'b0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_out;
  int model_txn   = 0;
  int model_stall = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Exact product of two 16-bit operands, signed or unsigned.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
    longint ea, eb, p;
    ea = s ? longint'($signed(a)) : longint'(a);
    eb = s ? longint'($signed(b)) : longint'(b);
    p  = ea * eb;
    return p[31:0];
  endfunction

  // One clock cycle. Called at posedge+1 after inputs are set; samples both
  // handshakes at posedge+2, then returns at the next posedge+1.
  task automatic tick();
    exp_t e;
    #1;
    last_acc  = in_valid && in_ready;
    last_cons = out_valid && out_ready;
    if (prev_stall) check("hold_stable", {out_valid, out_signed, product}, prev_out);
    prev_stall = out_valid && !out_ready;
    prev_out   = {out_valid, out_signed, product};
    if (out_valid && out_ready)  model_txn++;
    if (out_valid && !out_ready) model_stall++;
    if (last_cons) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("product", product, e.prod);
        check("out_signed", out_signed, e.sgn);
        last_lat  = cyc - e.acc_cyc;
        if (chk_lat) check("latency", last_lat, ST + 1);
        last_prod = product;
        n_out++;
      end
    end
    if (last_acc) begin
      e.prod    = ref_mul(multiplicand, multiplier, is_signed);
      e.sgn     = is_signed;
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic s);
    multiplicand = a;
    multiplier   = b;
    is_signed    = s;
    in_valid     = 1'b1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Asserts reset mid-cycle, checks the outputs clear without a clock edge,
  // holds it across an edge and releases it away from the edge.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_product", product, 0);
    check("arst_out_signed", out_signed, 0);
    exp_q.delete();
    prev_stall  = 1'b0;
    model_txn   = 0;
    model_stall = 0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pa [5];
    logic        ps [5];
    int          idx;
    int          n0;
    logic        seen;

    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    is_signed    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    check("rst_out_signed", out_signed, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef MULT_PIPE_STATS_EN
    check("rst_txn_count", txn_count, 0);
    check("rst_stall_count", stall_count, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Unsigned basic: 0xFFFF * 0xFFFF
    chk_lat = 1'b1;
    drive(16'hFFFF, 16'hFFFF, 1'b0);
    tick();
    check("basic_accept", last_acc, 1);
    drain();
    check("basic_prod", last_prod, 32'hFFFE_0001);
    check("basic_latency", last_lat, 3);

    // Signed mode
    drive(16'hFFFF, 16'h0002, 1'b1);
    tick();
    drain();
    check("signed_m1x2", last_prod, 32'hFFFF_FFFE);
    drive(16'h8000, 16'h8000, 1'b1);
    tick();
    drain();
    check("signed_min_sq", last_prod, 32'h4000_0000);

    // Back-to-back streaming, 100 random pairs
    n0 = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom));
      tick();
      check("stream_in_ready", last_acc, 1);
    end
    drain();
    check("stream_count", n_out - n0, 100);

    // Backpressure fill: only STAGES+1 pairs fit
    chk_lat = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pa[i] = 16'($urandom);
      ps[i] = 1'($urandom);
    end
    n0  = n_out;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(pa[idx], pa[4 - idx], ps[idx]);
      tick();
      if (last_acc) idx++;
    end
    check("fill_accepted", idx, 3);
    check("fill_in_ready", in_ready, 0);
    out_ready = 1'b1;
    drive(pa[idx], pa[4 - idx], ps[idx]);
    tick();
    check("simul_acc_cons", {last_acc, last_cons}, 2'b11);
    drain();
    check("fill_drained", n_out - n0, 4);

    // Reset with two transactions in flight, one already at the output
    out_ready = 1'b0;
    drive(16'h1234, 16'h5678, 1'b0);
    tick();
    drive(16'hABCD, 16'h0003, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_rst_inflight", exp_q.size(), 2);
    check("pre_rst_out_valid", out_valid, 1);
    mid_reset();
    check("post_rst_in_ready", in_ready, 1);
`ifdef MULT_PIPE_STATS_EN
    check("post_rst_txn_count", txn_count, 0);
    check("post_rst_stall_count", stall_count, 0);
`endif
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | out_valid;
    end
    check("no_stale_out", seen, 0);

`ifdef MULT_PIPE_STATS_EN
    // 5 transfers, 7 stalled cycles
    out_ready = 1'b0;
    drive(16'h0011, 16'h0022, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 7; i++) tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom));
      tick();
    end
    drain();
    check("stats_txn_5", txn_count, 5);
    check("stats_stall_7", stall_count, 7);
    mid_reset();
    check("stats_rst_txn", txn_count, 0);
    check("stats_rst_stall", stall_count, 0);
`endif

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      multiplicand = 16'($urandom);
      multiplier   = 16'($urandom);
      is_signed    = 1'($urandom);
      in_valid     = ($urandom_range(3) != 0);
      out_ready    = ($urandom_range(2) != 0);
      tick();
    end
    drain();
`ifdef MULT_PIPE_STATS_EN
    check("rand_txn_count", txn_count, model_txn);
    check("rand_stall_count", stall_count, model_stall);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
